// File: rtl/rename_reg_file_if.sv
// Issue/commit/read-port bundle for rename_reg_file.
// The master side (rename/ROB logic) drives requests; the slave side (register file) returns operands.
interface rename_reg_file_if #(
  parameter int REG_W = 5,
  parameter int VAL_W = 32,
  parameter int TAG_W = 4
);
  logic             rdy_in;
  logic             flush;
  logic             issue_en;
  logic [REG_W-1:0] issue_rd;
  logic [TAG_W-1:0] issue_tag;
  logic             commit_en;
  logic [REG_W-1:0] commit_rd;
  logic [VAL_W-1:0] commit_res;
  logic [TAG_W-1:0] commit_lab;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic [VAL_W-1:0] rf_val1;
  logic [VAL_W-1:0] rf_val2;
  logic [TAG_W-1:0] rf_label1;
  logic [TAG_W-1:0] rf_label2;
  logic             rf_busy1;
  logic             rf_busy2;

  modport master (
    output rdy_in, flush, issue_en, issue_rd, issue_tag,
    output commit_en, commit_rd, commit_res, commit_lab, rs1, rs2,
    input  rf_val1, rf_val2, rf_label1, rf_label2, rf_busy1, rf_busy2
  );

  modport slave (
    input  rdy_in, flush, issue_en, issue_rd, issue_tag,
    input  commit_en, commit_rd, commit_res, commit_lab, rs1, rs2,
    output rf_val1, rf_val2, rf_label1, rf_label2, rf_busy1, rf_busy2
  );
endinterface

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register rename tags (busy + producer ROB tag).
// Optional macro RF_COMMIT_BYPASS_EN forwards a matching commit to the read ports in the same cycle.
module rename_reg_file #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int VAL_W    = 32,
  parameter int TAG_W    = 4
) (
  input logic              clk,
  input logic              rst_in,
  rename_reg_file_if.slave bus
);

  localparam int PORT_W = VAL_W + TAG_W + 1;

  logic [VAL_W-1:0]    r_regs [NUM_REGS];
  logic [TAG_W-1:0]    r_tag  [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;

  logic              w_issue_fire;
  logic              w_commit_fire;
  logic              w_commit_clear;
  logic              w_hit1;
  logic              w_hit2;
  logic [PORT_W-1:0] w_port1;
  logic [PORT_W-1:0] w_port2;

  // Packs {value, busy, label} for one read port; x0 reads as idle zero, busy=0 forces label=0.
  function automatic logic [PORT_W-1:0] read_port(
    input logic [REG_W-1:0] rs,
    input logic [VAL_W-1:0] val,
    input logic             busy,
    input logic [TAG_W-1:0] tag,
    input logic             hit,
    input logic [VAL_W-1:0] res
  );
    logic [PORT_W-1:0] pkt;
    if (rs == {REG_W{1'b0}}) begin
      pkt = {PORT_W{1'b0}};
    end else if (hit) begin
      pkt = {res, 1'b0, {TAG_W{1'b0}}};
    end else if (busy) begin
      pkt = {val, 1'b1, tag};
    end else begin
      pkt = {val, 1'b0, {TAG_W{1'b0}}};
    end
    return pkt;
  endfunction

  // Qualify this cycle's issue and commit requests.
  always_comb begin
    w_issue_fire   = bus.rdy_in & bus.issue_en & ~bus.flush & (bus.issue_rd != {REG_W{1'b0}});
    w_commit_fire  = bus.rdy_in & bus.commit_en & (bus.commit_rd != {REG_W{1'b0}});
    w_commit_clear = 1'b0;
    // A stale commit tag or a same-cycle rename of the same register keeps the register busy.
    if (w_commit_fire && r_busy[bus.commit_rd] && (r_tag[bus.commit_rd] == bus.commit_lab) &&
        !(w_issue_fire && (bus.issue_rd == bus.commit_rd))) begin
      w_commit_clear = 1'b1;
    end else begin
      w_commit_clear = 1'b0;
    end
  end

  // Commit-bypass detection per read port.
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
`ifdef RF_COMMIT_BYPASS_EN
    if (w_commit_fire && (bus.commit_rd == bus.rs1) && r_busy[bus.rs1] &&
        (r_tag[bus.rs1] == bus.commit_lab)) begin
      w_hit1 = 1'b1;
    end else begin
      w_hit1 = 1'b0;
    end
    if (w_commit_fire && (bus.commit_rd == bus.rs2) && r_busy[bus.rs2] &&
        (r_tag[bus.rs2] == bus.commit_lab)) begin
      w_hit2 = 1'b1;
    end else begin
      w_hit2 = 1'b0;
    end
`else
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
`endif
  end

  // Register value, busy and tag state; rdy_in low freezes everything except reset.
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      r_busy <= {NUM_REGS{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= {VAL_W{1'b0}};
        r_tag[i]  <= {TAG_W{1'b0}};
      end
    end else if (bus.rdy_in) begin
      if (w_commit_fire) begin
        r_regs[bus.commit_rd] <= bus.commit_res;
      end
      if (bus.flush) begin
        r_busy <= {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
          r_tag[i] <= {TAG_W{1'b0}};
        end
      end else begin
        if (w_commit_clear) begin
          r_busy[bus.commit_rd] <= 1'b0;
          r_tag[bus.commit_rd]  <= {TAG_W{1'b0}};
        end
        if (w_issue_fire) begin
          r_busy[bus.issue_rd] <= 1'b1;
          r_tag[bus.issue_rd]  <= bus.issue_tag;
        end
      end
    end
  end

  // Read ports see only registered state (plus the optional commit bypass), never this cycle's issue.
  always_comb begin
    w_port1 = read_port(bus.rs1, r_regs[bus.rs1], r_busy[bus.rs1], r_tag[bus.rs1], w_hit1, bus.commit_res);
    w_port2 = read_port(bus.rs2, r_regs[bus.rs2], r_busy[bus.rs2], r_tag[bus.rs2], w_hit2, bus.commit_res);
  end

  assign bus.rf_val1   = w_port1[PORT_W-1 -: VAL_W];
  assign bus.rf_busy1  = w_port1[TAG_W];
  assign bus.rf_label1 = w_port1[TAG_W-1:0];
  assign bus.rf_val2   = w_port2[PORT_W-1 -: VAL_W];
  assign bus.rf_busy2  = w_port2[TAG_W];
  assign bus.rf_label2 = w_port2[TAG_W-1:0];

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed self-checking bench for rename_reg_file: reset, rename/commit, stale tags,
// same-cycle issue+commit, flush, x0 handling, rdy_in freeze and back-to-back traffic.
module tb_rename_reg_file;
  logic clk;
  logic rst_in;
  int   checks;
  int   errors;

  rename_reg_file_if #(.REG_W(5), .VAL_W(32), .TAG_W(4)) bus ();

  rename_reg_file #(.NUM_REGS(32), .REG_W(5), .VAL_W(32), .TAG_W(4)) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rdy_in    = 1'b1;
    bus.flush     = 1'b0;
    bus.issue_en  = 1'b0;
    bus.issue_rd  = 5'd0;
    bus.issue_tag = 4'd0;
    bus.commit_en = 1'b0;
    bus.commit_rd = 5'd0;
    bus.commit_res = 32'h0;
    bus.commit_lab = 4'd0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] tag);
    idle();
    bus.issue_en  = 1'b1;
    bus.issue_rd  = rd;
    bus.issue_tag = tag;
    cycle();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_in  = 1'b0;
    bus.rs1 = 5'd5;
    bus.rs2 = 5'd0;
    cycle();
    rst_in = 1'b1;
    #1;
    checks++; if (bus.rf_val1 !== 32'h0) begin errors++; $display("FAIL reset_val1 got %h exp %h", bus.rf_val1, 32'h0); end
    checks++; if (bus.rf_busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1 got %b exp 0", bus.rf_busy1); end
    checks++; if (bus.rf_label1 !== 4'd0) begin errors++; $display("FAIL reset_label1 got %0d exp 0", bus.rf_label1); end
  endtask

  task automatic test_issue_commit();
    idle();
    bus.issue_en = 1'b1; bus.issue_rd = 5'd3; bus.issue_tag = 4'd7; bus.rs1 = 5'd3;
    #1;
    checks++; if (bus.rf_busy1 !== 1'b0) begin errors++; $display("FAIL issue_not_visible_same_cycle got %b exp 0", bus.rf_busy1); end
    cycle();
    idle();
    #1;
    checks++; if (bus.rf_busy1 !== 1'b1) begin errors++; $display("FAIL issue_busy1 got %b exp 1", bus.rf_busy1); end
    checks++; if (bus.rf_label1 !== 4'd7) begin errors++; $display("FAIL issue_label1 got %0d exp 7", bus.rf_label1); end
    bus.commit_en = 1'b1; bus.commit_rd = 5'd3; bus.commit_lab = 4'd7; bus.commit_res = 32'hDEAD;
    bus.rs2 = 5'd3;
    #1;
`ifdef RF_COMMIT_BYPASS_EN
    checks++; if (bus.rf_val2 !== 32'hDEAD) begin errors++; $display("FAIL bypass_val2 got %h exp %h", bus.rf_val2, 32'hDEAD); end
    checks++; if (bus.rf_busy2 !== 1'b0) begin errors++; $display("FAIL bypass_busy2 got %b exp 0", bus.rf_busy2); end
`else
    checks++; if (bus.rf_val2 !== 32'h0) begin errors++; $display("FAIL nobypass_val2 got %h exp %h", bus.rf_val2, 32'h0); end
    checks++; if (bus.rf_busy2 !== 1'b1) begin errors++; $display("FAIL nobypass_busy2 got %b exp 1", bus.rf_busy2); end
`endif
    cycle();
    idle();
    #1;
    checks++; if (bus.rf_val1 !== 32'hDEAD) begin errors++; $display("FAIL commit_val1 got %h exp %h", bus.rf_val1, 32'hDEAD); end
    checks++; if (bus.rf_busy1 !== 1'b0) begin errors++; $display("FAIL commit_busy1 got %b exp 0", bus.rf_busy1); end
    checks++; if (bus.rf_label1 !== 4'd0) begin errors++; $display("FAIL commit_label1 got %0d exp 0", bus.rf_label1); end
  endtask

  task automatic test_stale_tag();
    issue(5'd4, 4'd2);
    issue(5'd4, 4'd9);
    bus.commit_en = 1'b1; bus.commit_rd = 5'd4; bus.commit_lab = 4'd2; bus.commit_res = 32'h11;
    cycle();
    idle();
    bus.rs2 = 5'd4;
    #1;
    checks++; if (bus.rf_val2 !== 32'h11) begin errors++; $display("FAIL stale_val2 got %h exp %h", bus.rf_val2, 32'h11); end
    checks++; if (bus.rf_busy2 !== 1'b1) begin errors++; $display("FAIL stale_busy2 got %b exp 1", bus.rf_busy2); end
    checks++; if (bus.rf_label2 !== 4'd9) begin errors++; $display("FAIL stale_label2 got %0d exp 9", bus.rf_label2); end
  endtask

  task automatic test_same_cycle();
    issue(5'd6, 4'd1);
    bus.issue_en = 1'b1; bus.issue_rd = 5'd6; bus.issue_tag = 4'd1;
    bus.commit_en = 1'b1; bus.commit_rd = 5'd6; bus.commit_lab = 4'd1; bus.commit_res = 32'h55;
    cycle();
    idle();
    bus.rs1 = 5'd6;
    #1;
    checks++; if (bus.rf_val1 !== 32'h55) begin errors++; $display("FAIL same_val1 got %h exp %h", bus.rf_val1, 32'h55); end
    checks++; if (bus.rf_busy1 !== 1'b1) begin errors++; $display("FAIL same_busy1 got %b exp 1", bus.rf_busy1); end
    checks++; if (bus.rf_label1 !== 4'd1) begin errors++; $display("FAIL same_label1 got %0d exp 1", bus.rf_label1); end
  endtask

  task automatic test_flush();
    issue(5'd10, 4'd3);
    issue(5'd11, 4'd4);
    issue(5'd8, 4'd5);
    bus.flush = 1'b1;
    bus.commit_en = 1'b1; bus.commit_rd = 5'd8; bus.commit_lab = 4'd0; bus.commit_res = 32'h77;
    bus.issue_en = 1'b1; bus.issue_rd = 5'd9; bus.issue_tag = 4'd6;
    cycle();
    idle();
    bus.rs1 = 5'd8; bus.rs2 = 5'd4;
    #1;
    checks++; if (bus.rf_val1 !== 32'h77) begin errors++; $display("FAIL flush_val8 got %h exp %h", bus.rf_val1, 32'h77); end
    checks++; if (bus.rf_busy1 !== 1'b0) begin errors++; $display("FAIL flush_busy8 got %b exp 0", bus.rf_busy1); end
    checks++; if (bus.rf_val2 !== 32'h11) begin errors++; $display("FAIL flush_val4_kept got %h exp %h", bus.rf_val2, 32'h11); end
    checks++; if ({bus.rf_busy2, bus.rf_label2} !== 5'd0) begin errors++; $display("FAIL flush_busy4 got %b exp 00000", {bus.rf_busy2, bus.rf_label2}); end
    bus.rs1 = 5'd9; bus.rs2 = 5'd10;
    #1;
    checks++; if (bus.rf_busy1 !== 1'b0) begin errors++; $display("FAIL flush_issue9_dropped got %b exp 0", bus.rf_busy1); end
    checks++; if (bus.rf_busy2 !== 1'b0) begin errors++; $display("FAIL flush_busy10 got %b exp 0", bus.rf_busy2); end
    bus.rs1 = 5'd11; bus.rs2 = 5'd6;
    #1;
    checks++; if (bus.rf_busy1 !== 1'b0) begin errors++; $display("FAIL flush_busy11 got %b exp 0", bus.rf_busy1); end
    checks++; if ({bus.rf_val2, bus.rf_busy2} !== {32'h55, 1'b0}) begin errors++; $display("FAIL flush_reg6 got %h/%b exp 55/0", bus.rf_val2, bus.rf_busy2); end
  endtask

  task automatic test_x0_and_rdy();
    bus.issue_en = 1'b1; bus.issue_rd = 5'd0; bus.issue_tag = 4'd3;
    bus.commit_en = 1'b1; bus.commit_rd = 5'd0; bus.commit_lab = 4'd3; bus.commit_res = 32'hFF;
    cycle();
    idle();
    bus.rs1 = 5'd0;
    #1;
    checks++; if ({bus.rf_val1, bus.rf_busy1, bus.rf_label1} !== 37'd0) begin errors++; $display("FAIL x0_read got %h/%b/%0d exp 0/0/0", bus.rf_val1, bus.rf_busy1, bus.rf_label1); end
    bus.rdy_in = 1'b0;
    bus.issue_en = 1'b1; bus.issue_rd = 5'd2; bus.issue_tag = 4'd5;
    bus.commit_en = 1'b1; bus.commit_rd = 5'd3; bus.commit_lab = 4'd0; bus.commit_res = 32'h1234;
    bus.rs1 = 5'd2; bus.rs2 = 5'd3;
    #1;
    checks++; if (bus.rf_val2 !== 32'hDEAD) begin errors++; $display("FAIL rdy0_live_read got %h exp %h", bus.rf_val2, 32'hDEAD); end
    cycle();
    idle();
    #1;
    checks++; if (bus.rf_busy1 !== 1'b0) begin errors++; $display("FAIL rdy0_issue_blocked got %b exp 0", bus.rf_busy1); end
    checks++; if (bus.rf_val2 !== 32'hDEAD) begin errors++; $display("FAIL rdy0_commit_blocked got %h exp %h", bus.rf_val2, 32'hDEAD); end
  endtask

  task automatic test_back_to_back();
    bus.issue_en = 1'b1; bus.issue_rd = 5'd12; bus.issue_tag = 4'd15;
    bus.commit_en = 1'b1; bus.commit_rd = 5'd13; bus.commit_lab = 4'd0; bus.commit_res = 32'h13;
    cycle();
    bus.issue_en = 1'b1; bus.issue_rd = 5'd13; bus.issue_tag = 4'd0;
    bus.commit_en = 1'b1; bus.commit_rd = 5'd12; bus.commit_lab = 4'd15; bus.commit_res = 32'hC0FFEE;
    cycle();
    idle();
    bus.rs1 = 5'd12; bus.rs2 = 5'd13;
    #1;
    checks++; if ({bus.rf_val1, bus.rf_busy1} !== {32'hC0FFEE, 1'b0}) begin errors++; $display("FAIL b2b_reg12 got %h/%b exp c0ffee/0", bus.rf_val1, bus.rf_busy1); end
    checks++; if (bus.rf_val2 !== 32'h13) begin errors++; $display("FAIL b2b_val13 got %h exp %h", bus.rf_val2, 32'h13); end
    checks++; if ({bus.rf_busy2, bus.rf_label2} !== 5'b1_0000) begin errors++; $display("FAIL b2b_tag0_busy13 got %b exp 10000", {bus.rf_busy2, bus.rf_label2}); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_in = 1'b1;
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd0;
    idle();
    @(negedge clk);
    test_reset();
    test_issue_commit();
    test_stale_tag();
    test_same_cycle();
    test_flush();
    test_x0_and_rdy();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
